// File: rtl/shift_reg_universal.sv
// Universal WIDTH-bit register: hold / shift right / shift left / load, with saturating shift counter.
// Optional rotate (rot port) is enabled by defining SHIFT_REG_UNIVERSAL_ROTATE_EN.
module shift_reg_universal #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             pr,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
`ifdef SHIFT_REG_UNIVERSAL_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CW-1:0]    cnt,
    output logic             full
);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    r_cnt;

    logic             w_in_r;
    logic             w_in_l;
    logic             w_full;
    logic [CW-1:0]    w_cnt_inc;
    logic [WIDTH-1:0] w_q_nxt;
    logic [CW-1:0]    w_cnt_nxt;

`ifdef SHIFT_REG_UNIVERSAL_ROTATE_EN
    // Rotation recirculates the bit that is shifted out.
    assign w_in_r = rot ? r_q[0]       : sin_r;
    assign w_in_l = rot ? r_q[WIDTH-1] : sin_l;
`else
    assign w_in_r = sin_r;
    assign w_in_l = sin_l;
`endif

    assign w_full    = (r_cnt == CNT_MAX);
    assign w_cnt_inc = w_full ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_q_nxt   = r_q;
        w_cnt_nxt = r_cnt;
        if (pr) begin
            w_q_nxt   = {WIDTH{1'b1}};
            w_cnt_nxt = '0;
        end else if (en) begin
            case (mode)
                MODE_HOLD: begin
                    w_q_nxt   = r_q;
                    w_cnt_nxt = r_cnt;
                end
                MODE_SHR: begin
                    w_q_nxt   = {w_in_r, r_q[WIDTH-1:1]};
                    w_cnt_nxt = w_cnt_inc;
                end
                MODE_SHL: begin
                    w_q_nxt   = {r_q[WIDTH-2:0], w_in_l};
                    w_cnt_nxt = w_cnt_inc;
                end
                MODE_LOAD: begin
                    w_q_nxt   = d;
                    w_cnt_nxt = '0;
                end
                default: begin
                    w_q_nxt   = r_q;
                    w_cnt_nxt = r_cnt;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_q   <= '0;
            r_cnt <= '0;
        end else begin
            r_q   <= w_q_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    assign q      = r_q;
    assign cnt    = r_cnt;
    assign full   = w_full;
    assign sout_r = r_q[0];
    assign sout_l = r_q[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_universal.sv
// Directed self-checking bench for shift_reg_universal (WIDTH=8).
// Rotate vectors run only when SHIFT_REG_UNIVERSAL_ROTATE_EN is defined.
module tb_shift_reg_universal;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 1);

    logic             clk;
    logic             clr;
    logic             pr;
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin_r;
    logic             sin_l;
`ifdef SHIFT_REG_UNIVERSAL_ROTATE_EN
    logic             rot;
`endif
    logic [WIDTH-1:0] q;
    logic             sout_r;
    logic             sout_l;
    logic [CW-1:0]    cnt;
    logic             full;

    int nvec;
    int nerr;

    shift_reg_universal #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .clr    (clr),
        .pr     (pr),
        .en     (en),
        .mode   (mode),
        .d      (d),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
`ifdef SHIFT_REG_UNIVERSAL_ROTATE_EN
        .rot    (rot),
`endif
        .q      (q),
        .sout_r (sout_r),
        .sout_l (sout_l),
        .cnt    (cnt),
        .full   (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] pat_r;
        logic [7:0] pat_l;
        nvec  = 0;
        nerr  = 0;
        pat_r = 8'hA5;
        pat_l = 8'b1100_1010;

        // reset with arbitrary inputs
        clr   = 1'b1;
        pr    = 1'b0;
        en    = 1'b1;
        mode  = 2'b11;
        d     = 8'hFF;
        sin_r = 1'b1;
        sin_l = 1'b1;
`ifdef SHIFT_REG_UNIVERSAL_ROTATE_EN
        rot   = 1'b0;
`endif
        repeat (2) tick();
        chk("rst_q", 32'(q), 32'h00);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_sout_r", 32'(sout_r), 32'd0);
        chk("rst_sout_l", 32'(sout_l), 32'd0);

        // first edge with clr low performs the load
        clr  = 1'b0;
        d    = 8'hA5;
        mode = 2'b11;
        tick();
        chk("load_q", 32'(q), 32'hA5);
        chk("load_cnt", 32'(cnt), 32'd0);

        mode = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_q", 32'(q), 32'hA5);
            chk("hold_cnt", 32'(cnt), 32'd0);
        end

        en   = 1'b0;
        mode = 2'b11;
        d    = 8'h3C;
        tick();
        chk("en0_load_q", 32'(q), 32'hA5);

        // serialise right
        en    = 1'b1;
        mode  = 2'b01;
        sin_r = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("shr_sout_r", 32'(sout_r), 32'(pat_r[i]));
            tick();
            chk("shr_cnt", 32'(cnt), 32'(i + 1));
            chk("shr_full", 32'(full), (i == 7) ? 32'd1 : 32'd0);
        end
        chk("shr_q", 32'(q), 32'h00);
        tick();
        chk("shr_sat_cnt", 32'(cnt), 32'd8);
        chk("shr_sat_full", 32'(full), 32'd1);

        // en=0 freezes q and counter
        en    = 1'b0;
        sin_r = 1'b1;
        tick();
        chk("en0_shr_q", 32'(q), 32'h00);
        chk("en0_shr_cnt", 32'(cnt), 32'd8);

        // preset beats en=0 and load
        pr   = 1'b1;
        mode = 2'b11;
        d    = 8'h00;
        tick();
        chk("pr_q", 32'(q), 32'hFF);
        chk("pr_cnt", 32'(cnt), 32'd0);
        chk("pr_full", 32'(full), 32'd0);
        pr = 1'b0;

        // clr mid-cycle clears before the next edge
        en   = 1'b1;
        mode = 2'b11;
        d    = 8'h5A;
        tick();
        chk("ld5a_q", 32'(q), 32'h5A);
        #2;
        clr = 1'b1;
        #1;
        chk("async_clr_q", 32'(q), 32'h00);
        chk("async_clr_sout_l", 32'(sout_l), 32'd0);
        tick();
        clr = 1'b0;

        // deserialise left
        mode = 2'b10;
        for (int i = 0; i < 8; i++) begin
            sin_l = pat_l[7-i];
            tick();
            chk("shl_full", 32'(full), (i == 7) ? 32'd1 : 32'd0);
        end
        chk("shl_q", 32'(q), 32'hCA);
        chk("shl_sout_l", 32'(sout_l), 32'd1);
        chk("shl_sout_r", 32'(sout_r), 32'd0);

        // clr and pr together: clr wins
        pr  = 1'b1;
        clr = 1'b1;
        tick();
        chk("clr_pr_q", 32'(q), 32'h00);
        chk("clr_pr_cnt", 32'(cnt), 32'd0);
        pr  = 1'b0;
        clr = 1'b0;

`ifdef SHIFT_REG_UNIVERSAL_ROTATE_EN
        mode = 2'b11;
        d    = 8'h81;
        tick();
        rot  = 1'b1;
        mode = 2'b01;
        sin_r = 1'b0;
        tick();
        chk("rotr_q", 32'(q), 32'hC0);
        chk("rotr_cnt", 32'(cnt), 32'd1);
        mode  = 2'b10;
        sin_l = 1'b0;
        repeat (2) tick();
        chk("rotl_q", 32'(q), 32'h03);
        chk("rotl_cnt", 32'(cnt), 32'd3);
        rot = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
